// File: rtl/cam_array.sv
// Purpose: CAM storage array: per-entry data and valid flags, one read port, flattened view for search.
// Latency: writes/invalidates visible on eff_out_* after one edge; read data registered, 1 cycle.
// Backpressure: none; every request is accepted each cycle. Option macro: CAM_OCCUPANCY_EN (occupancy_o).
module cam_array #(
    parameter int NUM_ELEMS = 32,
    parameter int WORD_BITS = 5,
    parameter int WORD_SIZE = 2**WORD_BITS
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           write_i,
    input  logic [WORD_BITS-1:0]           write_index_i,
    input  logic [WORD_SIZE-1:0]           write_data_i,
    input  logic                           invalidate_i,
    input  logic [WORD_BITS-1:0]           invalidate_index_i,
    input  logic                           read_i,
    input  logic [WORD_BITS-1:0]           read_index_i,
    output logic                           read_valid_o,
    output logic [WORD_SIZE-1:0]           read_value_o,
    output logic [WORD_SIZE*NUM_ELEMS-1:0] eff_out_data,
`ifdef CAM_OCCUPANCY_EN
    output logic [WORD_BITS:0]             occupancy_o,
`endif
    output logic [NUM_ELEMS-1:0]           eff_out_valid
);

    // Index bound, one bit wider than an index so NUM_ELEMS == 2**WORD_BITS is representable.
    localparam logic [WORD_BITS:0] LP_NUM_ELEMS = (WORD_BITS+1)'(NUM_ELEMS);

    logic [NUM_ELEMS-1:0][WORD_SIZE-1:0] r_data;
    logic [NUM_ELEMS-1:0]                r_valid;
    logic                                r_read_valid;
    logic [WORD_SIZE-1:0]                r_read_value;

    logic w_wr_ok;
    logic w_inv_ok;
    logic w_rd_ok;

    // Requests to indices beyond the array are dropped.
    assign w_wr_ok  = write_i      && ({1'b0, write_index_i}      < LP_NUM_ELEMS);
    assign w_inv_ok = invalidate_i && ({1'b0, invalidate_index_i} < LP_NUM_ELEMS);
    assign w_rd_ok  = read_i       && ({1'b0, read_index_i}       < LP_NUM_ELEMS);

    // Storage update; the invalidate is ordered after the write so it wins on a shared index.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            if (w_wr_ok) begin
                r_data[write_index_i]  <= write_data_i;
                r_valid[write_index_i] <= 1'b1;
            end
            if (w_inv_ok) begin
                r_valid[invalidate_index_i] <= 1'b0;
            end
        end
    end

    // Registered read port: samples pre-write contents; value holds while idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_read_valid <= 1'b0;
            r_read_value <= '0;
        end else begin
            r_read_valid <= w_rd_ok && r_valid[read_index_i];
            if (read_i) begin
                r_read_value <= w_rd_ok ? r_data[read_index_i] : '0;
            end
        end
    end

    assign read_valid_o  = r_read_valid;
    assign read_value_o  = r_read_value;
    assign eff_out_data  = r_data;
    assign eff_out_valid = r_valid;

`ifdef CAM_OCCUPANCY_EN
    logic [WORD_BITS:0] r_occupancy;
    logic               w_occ_inc;
    logic               w_occ_dec;

    // A write only adds an entry if it was empty and is not cancelled by a same-index invalidate.
    assign w_occ_inc = w_wr_ok && !r_valid[write_index_i]
                       && !(w_inv_ok && (invalidate_index_i == write_index_i));
    assign w_occ_dec = w_inv_ok && r_valid[invalidate_index_i];

    // Valid-entry counter tracking popcount(r_valid).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_occupancy <= '0;
        end else begin
            case ({w_occ_inc, w_occ_dec})
                2'b10:   r_occupancy <= r_occupancy + (WORD_BITS+1)'(1);
                2'b01:   r_occupancy <= r_occupancy - (WORD_BITS+1)'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    assign occupancy_o = r_occupancy;
`endif

endmodule

// File: doc/cam_array.md
CAM_ARRAY -- requirements
Module: cam_array

Interface
REQ-001 Parameter NUM_ELEMS, default 32, number of storage entries.
REQ-002 Parameter WORD_BITS, default 5, index width; SHALL satisfy 2**WORD_BITS >= NUM_ELEMS.
REQ-003 Parameter WORD_SIZE, default 2**WORD_BITS, data word width in bits.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_i  input  1  reset, synchronous, active-high.
REQ-006 write_i  input  1  write request, sampled each rising edge.
REQ-007 write_index_i  input  WORD_BITS  entry written.
REQ-008 write_data_i  input  WORD_SIZE  data written.
REQ-009 invalidate_i  input  1  invalidate request.
REQ-010 invalidate_index_i  input  WORD_BITS  entry invalidated.
REQ-011 read_i  input  1  read request.
REQ-012 read_index_i  input  WORD_BITS  entry read.
REQ-013 read_valid_o  output  1  registered: addressed entry was valid.
REQ-014 read_value_o  output  WORD_SIZE  registered read data.
REQ-015 eff_out_data  output  WORD_SIZE*NUM_ELEMS  all entries flattened; entry i at bits [WORD_SIZE*i +: WORD_SIZE]; feeds the search stage.
REQ-016 eff_out_valid  output  NUM_ELEMS  per-entry valid bits; bit i pairs with entry i.

Function
REQ-017 eff_out_data and eff_out_valid SHALL be driven directly from storage flops; no combinational path from any input.
REQ-018 write_i=1: entry write_index_i data := write_data_i and valid := 1 at the next edge.
REQ-019 invalidate_i=1: entry invalidate_index_i valid := 1'b0 at the next edge; data unchanged.
REQ-020 Write and invalidate, same index, same cycle: invalidate wins; valid=0, data still updated.
REQ-021 Write and invalidate, different indices, same cycle: both take effect.
REQ-022 read_i=1: next cycle read_valid_o = sampled entry valid, read_value_o = sampled entry data (1-cycle latency).
REQ-023 Read and write to the same index in one cycle: read returns pre-write contents (read-before-write).
REQ-024 read_i=0: read_valid_o := 0 next cycle; read_value_o holds its last value.
REQ-025 Any index >= NUM_ELEMS: write/invalidate ignored; read returns read_valid_o=0, read_value_o=0.
REQ-026 Rewriting a valid entry overwrites data; valid stays 1.

Reset
REQ-027 reset_i=1 at an edge: all valid bits := 0, all data := 0, read_valid_o := 0, read_value_o := 0.
REQ-028 Reset SHALL dominate all same-cycle write, invalidate and read requests.
REQ-029 First request honoured is the one sampled at the first edge with reset_i=0.

Configuration
REQ-030 Macro CAM_OCCUPANCY_EN defined: adds output occupancy_o, width WORD_BITS+1, count of valid entries, registered.
REQ-031 occupancy_o: +1 on write to an invalid entry, -1 on invalidate of a valid entry, net change when both occur (same index per REQ-020); reset value 0; equals popcount(eff_out_valid) every cycle.
REQ-032 Macro undefined: occupancy_o and its counter absent; all other behaviour identical.

Verification
REQ-033 Reset, then write idx 3 data 32'hDEADBEEF -> next cycle eff_out_valid[3]=1, eff_out_data[127:96]=32'hDEADBEEF.
REQ-034 Write idx 7 data 32'h1 with read idx 7 same cycle, entry previously empty -> read_valid_o=0, read_value_o=0; read again next cycle -> read_valid_o=1, read_value_o=32'h1.
REQ-035 Write idx 5 plus invalidate idx 5 same cycle -> eff_out_valid[5]=0, entry 5 data = written value.
REQ-036 Fill all 32 entries, then assert reset_i together with write idx 0 -> all eff_out_valid=0, all data 0, occupancy_o=0 (CAM_OCCUPANCY_EN).
REQ-037 With CAM_OCCUPANCY_EN: write idx 0,1,2, rewrite idx 1, invalidate idx 2, invalidate idx 9 (empty) -> occupancy_o sequence 1,2,3,3,2,2.
